// File: rtl/seq_share_arbiter_if.sv
// Request/grant bundle between client logic and the shared pattern sequencer.
// Clients drive req/hold; the arbiter drives grant, pattern and status.
interface seq_share_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] req;
    logic            hold;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [2:0]      number;
    logic            busy;
    logic            pass_done;

    modport master (
        output req, hold,
        input  gnt, gnt_id, number, busy, pass_done
    );

    modport slave (
        input  req, hold,
        output gnt, gnt_id, number, busy, pass_done
    );
endinterface

// File: rtl/seq_share_arbiter.sv
// Round-robin owner of a 3-bit pattern sequencer; grant lands one edge after a request seen in IDLE.
// hold freezes the running pass; passes are never pre-empted and grants are always separated by an IDLE cycle.
module seq_share_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWELL  = 4,
    parameter int PASSES = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    seq_share_arbiter_if.slave   io_bus
);
    localparam int IDW = $clog2(NREQ);
    localparam int DWW = $clog2(DWELL + 1);
    localparam int PSW = $clog2(PASSES + 1);

    localparam logic [2:0] P_START = 3'b000;
    localparam logic [2:0] P_A     = 3'b101;
    localparam logic [2:0] P_B     = 3'b001;
    localparam logic [2:0] P_DWELL = 3'b011;
    localparam logic [2:0] P_END   = 3'b110;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t          r_state, w_state_nxt;
    logic [NREQ-1:0] r_gnt, w_gnt_nxt;
    logic [IDW-1:0]  r_gnt_id, w_gnt_id_nxt;
    logic [2:0]      r_number, w_number_nxt;
    logic [DWW-1:0]  r_dwell, w_dwell_nxt;
    logic [PSW-1:0]  r_pass, w_pass_nxt;
    logic [IDW-1:0]  r_last, w_last_nxt;
    logic [IDW-1:0]  w_winner;
    logic            w_found;

    // Search upward from the slot after the last winner, wrapping at NREQ.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        w_winner = '0;
        w_found  = 1'b0;
        idx      = 0;
        cand     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(r_last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            cand = IDW'(idx);
            if (!w_found && io_bus.req[cand]) begin
                w_winner = cand;
                w_found  = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_number_nxt = r_number;
        w_dwell_nxt  = r_dwell;
        w_pass_nxt   = r_pass;
        w_last_nxt   = r_last;
        case (r_state)
            ST_IDLE: begin
                w_number_nxt = P_START;
                if (w_found) begin
                    w_state_nxt  = ST_RUN;
                    w_gnt_nxt    = NREQ'(1) << w_winner;
                    w_gnt_id_nxt = w_winner;
                    w_dwell_nxt  = '0;
                    w_pass_nxt   = '0;
                end
            end
            ST_RUN: begin
                if (!io_bus.hold) begin
                    case (r_number)
                        P_START: w_number_nxt = P_A;
                        P_A:     w_number_nxt = P_B;
                        P_B:     w_number_nxt = P_DWELL;
                        P_DWELL: begin
                            if (r_dwell == DWW'(DWELL - 1)) begin
                                w_number_nxt = P_END;
                                w_dwell_nxt  = '0;
                            end else begin
                                w_dwell_nxt = r_dwell + 1'b1;
                            end
                        end
                        P_END: begin
                            // Another pass only if the owner still wants it and budget remains.
                            if ((int'(r_pass) + 1 < PASSES) && io_bus.req[r_gnt_id]) begin
                                w_pass_nxt   = r_pass + 1'b1;
                                w_number_nxt = P_START;
                            end else begin
                                w_last_nxt   = r_gnt_id;
                                w_gnt_nxt    = '0;
                                w_gnt_id_nxt = '0;
                                w_number_nxt = P_START;
                                w_state_nxt  = ST_IDLE;
                            end
                        end
                        default: w_number_nxt = P_START;
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_number <= P_START;
            r_dwell  <= '0;
            r_pass   <= '0;
            r_last   <= IDW'(NREQ - 1);
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_number <= w_number_nxt;
            r_dwell  <= w_dwell_nxt;
            r_pass   <= w_pass_nxt;
            r_last   <= w_last_nxt;
        end
    end

    assign io_bus.gnt       = r_gnt;
    assign io_bus.gnt_id    = r_gnt_id;
    assign io_bus.number    = r_number;
    assign io_bus.busy      = (r_state == ST_RUN);
    assign io_bus.pass_done = (r_state == ST_RUN) && (r_number == P_END) && !io_bus.hold;
endmodule

// File: tb/tb_seq_share_arbiter.sv
// Bench: three arbiters (base, PASSES=2, DWELL=1) driven by shared req/hold and
// compared each cycle with a position-in-pass reference model.
module tb_seq_share_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       hold = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    seq_share_arbiter_if #(.NREQ(4)) ifa ();
    seq_share_arbiter_if #(.NREQ(4)) ifb ();
    seq_share_arbiter_if #(.NREQ(4)) ifc ();
    assign ifa.req = req;  assign ifa.hold = hold;
    assign ifb.req = req;  assign ifb.hold = hold;
    assign ifc.req = req;  assign ifc.hold = hold;

    seq_share_arbiter #(.NREQ(4), .DWELL(4), .PASSES(1)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .io_bus(ifa));
    seq_share_arbiter #(.NREQ(4), .DWELL(4), .PASSES(2)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .io_bus(ifb));
    seq_share_arbiter #(.NREQ(4), .DWELL(1), .PASSES(1)) dut_c (.i_clk(clk), .i_rst_n(rst_n), .io_bus(ifc));

    // Model: a grant is an owner plus a position within the pass (0 .. 3+DWELL).
    bit m_act[3];
    int m_id[3], m_pos[3], m_pass[3], m_last[3];

    function automatic int dw(int k);
        return (k == 2) ? 1 : 4;
    endfunction

    function automatic int ps(int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic logic [2:0] pattern(int pos, int d);
        if (pos == 0) return 3'b000;
        if (pos == 1) return 3'b101;
        if (pos == 2) return 3'b001;
        if (pos < 3 + d) return 3'b011;
        return 3'b110;
    endfunction

    function automatic logic [10:0] exp_vec(int k);
        logic [3:0] g;
        logic [1:0] id;
        logic       pd;
        g  = m_act[k] ? (4'b0001 << m_id[k]) : 4'b0000;
        id = m_act[k] ? 2'(m_id[k]) : 2'b00;
        pd = m_act[k] && (m_pos[k] == 3 + dw(k)) && !hold;
        return {g, id, m_act[k] ? pattern(m_pos[k], dw(k)) : 3'b000, m_act[k], pd};
    endfunction

    function automatic logic [10:0] dut_vec(int k);
        case (k)
            0:       return {ifa.gnt, ifa.gnt_id, ifa.number, ifa.busy, ifa.pass_done};
            1:       return {ifb.gnt, ifb.gnt_id, ifb.number, ifb.busy, ifb.pass_done};
            default: return {ifc.gnt, ifc.gnt_id, ifc.number, ifc.busy, ifc.pass_done};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_act[k] = 0; m_id[k] = 0; m_pos[k] = 0; m_pass[k] = 0; m_last[k] = 3;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (!m_act[k]) begin
                for (int i = 1; i <= 4; i++) begin
                    int idx = (m_last[k] + i) % 4;
                    if (!m_act[k] && req[idx]) begin
                        m_act[k] = 1; m_id[k] = idx; m_pos[k] = 0; m_pass[k] = 0;
                    end
                end
            end else if (!hold) begin
                if (m_pos[k] == 3 + dw(k)) begin
                    if (m_pass[k] + 1 < ps(k) && req[m_id[k]]) begin
                        m_pass[k]++; m_pos[k] = 0;
                    end else begin
                        m_last[k] = m_id[k]; m_act[k] = 0; m_pos[k] = 0;
                    end
                end else begin
                    m_pos[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        req = 4'b0; hold = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dut_vec(k) !== 11'b0) begin
                bad++; $display("FAIL reset_state k=%0d got=%h exp=000", k, dut_vec(k));
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL single k=%0d cyc=%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] q_g[$];
        int q_len[$], q_gap[$];
        int run = 0, gap = 0;
        bit prev = 0;
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL round_robin k=%0d cyc=%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            if (ifa.busy && !prev) begin
                q_g.push_back(ifa.gnt);
                if (q_g.size() > 1) q_gap.push_back(gap);
                run = 0;
            end
            if (!ifa.busy && prev) begin q_len.push_back(run); gap = 0; end
            if (ifa.busy) run++; else gap++;
            prev = ifa.busy;
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (i >= q_g.size() || q_g[i] !== exp_g[i]) begin
                bad++; $display("FAIL rr_order idx=%0d got=%b exp=%b", i, (i < q_g.size()) ? q_g[i] : 4'bx, exp_g[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (i >= q_len.size() || q_len[i] != 8 || i >= q_gap.size() || q_gap[i] != 1) begin
                bad++; $display("FAIL rr_timing idx=%0d len=%0d gap=%0d exp len=8 gap=1", i,
                                (i < q_len.size()) ? q_len[i] : -1, (i < q_gap.size()) ? q_gap[i] : -1);
            end
        end
    endtask

    task automatic test_hold();
        int held = 0, busy_cnt = 0, pd_cnt = 0;
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 16; c++) begin
            hold = (m_act[0] && m_pos[0] == 3 && held < 3);
            if (hold) held++;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL hold k=%0d cyc=%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            if (c < 13) begin
                busy_cnt += int'(ifa.busy);
                pd_cnt   += int'(ifa.pass_done);
            end
            if (c == 12) req = 4'b0000;
            tick();
        end
        hold = 1'b0;
        total++;
        if (busy_cnt != 11 || pd_cnt != 1) begin
            bad++; $display("FAIL hold_len busy=%0d pass_done=%0d exp 11 and 1", busy_cnt, pd_cnt);
        end
    endtask

    task automatic test_multi_pass();
        int run_b;
        for (int mode = 0; mode < 2; mode++) begin
            do_reset();
            req = 4'b0001;
            run_b = 0;
            for (int c = 0; c < 20; c++) begin
                if (mode == 1 && c == 3) req = 4'b0000;
                if (mode == 0 && c == 17) req = 4'b0000;
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    total++;
                    if (dut_vec(k) !== exp_vec(k)) begin
                        bad++; $display("FAIL multi_pass k=%0d mode=%0d cyc=%0d got=%h exp=%h", k, mode, c, dut_vec(k), exp_vec(k));
                    end
                end
                if (c <= 17) run_b += int'(ifb.busy);
                tick();
            end
            total++;
            if (run_b != ((mode == 0) ? 16 : 8)) begin
                bad++; $display("FAIL multi_pass_len mode=%0d got=%0d exp=%0d", mode, run_b, (mode == 0) ? 16 : 8);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        total++;
        if (ifa.number !== 3'b001) begin
            bad++; $display("FAIL arst_setup got=%b exp=001", ifa.number);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dut_vec(k) !== 11'b0) begin
                bad++; $display("FAIL arst_immediate k=%0d got=%h exp=000", k, dut_vec(k));
            end
        end
        req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            total++;
            if (dut_vec(k) !== exp_vec(k) || dut_vec(k)[10:7] !== 4'b0010) begin
                bad++; $display("FAIL arst_first_grant k=%0d got=%h exp=%h", k, dut_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_wrap_dwell1();
        do_reset();
        req = 4'b1000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL wrap k=%0d cyc=%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            if (c == 1) begin
                total++;
                if (ifc.gnt !== 4'b1000 || ifc.gnt_id !== 2'd3) begin
                    bad++; $display("FAIL wrap_grant got=%b/%0d exp=1000/3", ifc.gnt, ifc.gnt_id);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            hold = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                total++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    bad++; $display("FAIL random k=%0d cyc=%0d got=%h exp=%h", k, c, dut_vec(k), exp_vec(k));
                end
            end
            tick();
        end
        hold = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_multi_pass();
        test_async_reset();
        test_wrap_dwell1();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
